// File: rtl/phase_bus_cmd_scheduler_if.sv
// Phase-bus command scheduler bus bundle.
// It carries the host command handshake, the sub-state-machine active/complete lines,
// and the response-path handshake.
interface phase_bus_cmd_scheduler_if;

   localparam int unsigned ID_W     = 3;
   localparam int unsigned TYPE_W   = 2;
   localparam int unsigned NUM_SUB  = 5;
   localparam int unsigned COUNT_W  = 4;
   localparam int unsigned STATUS_W = 2;

   logic                cmd_valid;
   logic                cmd_ready;
   logic [ID_W-1:0]     cmd_id;
   logic [TYPE_W-1:0]   cmd_type;
   logic [NUM_SUB-1:0]  active_o;
   logic [NUM_SUB-1:0]  complete_i;
   logic [COUNT_W-1:0]  resp_count_i;
   logic [TYPE_W-1:0]   cmd_type_o;
   logic                resp_valid;
   logic                resp_ready;
   logic [STATUS_W-1:0] resp_status;
   logic [COUNT_W-1:0]  resp_count;
   logic                busy;

   // Host / sub-block / response-path side
   modport master (
      output cmd_valid, cmd_id, cmd_type, complete_i, resp_count_i, resp_ready,
      input  cmd_ready, active_o, cmd_type_o, resp_valid, resp_status, resp_count, busy
   );

   // Scheduler side
   modport slave (
      input  cmd_valid, cmd_id, cmd_type, complete_i, resp_count_i, resp_ready,
      output cmd_ready, active_o, cmd_type_o, resp_valid, resp_status, resp_count, busy
   );

endinterface

// File: rtl/phase_bus_cmd_scheduler.sv
// Phase-bus command scheduler.
// It accepts one decoded host command at a time and drives exactly one substate_*_active line.
// It then waits for the matching completion and its release, and returns status and byte count.
module phase_bus_cmd_scheduler #(
   parameter int unsigned CLOCK_FREQUENCY = 27000000,
   parameter int unsigned TIMEOUT_CYCLES  = 4096
) (
   input logic                          clock,
   input logic                          reset,
   phase_bus_cmd_scheduler_if.slave     bus
);

   localparam int unsigned TIMER_W  = 13;
   localparam int unsigned NUM_SUB  = 5;
   localparam int unsigned ID_W     = 3;
   localparam int unsigned COUNT_W  = 4;
   localparam int unsigned STATUS_W = 2;

   localparam logic [ID_W-1:0]     ID_MAX        = ID_W'(NUM_SUB - 1);
   localparam logic [TIMER_W-1:0]  TIMER_LAST    = TIMER_W'(TIMEOUT_CYCLES - 1);
   localparam logic [TIMER_W-1:0]  TIMER_SAT     = '1;
   localparam logic [STATUS_W-1:0] STATUS_OK     = STATUS_W'(0);
   localparam logic [STATUS_W-1:0] STATUS_ILLEGAL = STATUS_W'(1);
   localparam logic [STATUS_W-1:0] STATUS_TIMEOUT = STATUS_W'(2);
   localparam logic [STATUS_W-1:0] STATUS_STUCK  = STATUS_W'(3);

   // Reject parameter sets the 13-bit timer cannot represent
   if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > (2 ** TIMER_W) || CLOCK_FREQUENCY == 0) begin : g_param_check
      $error("phase_bus_cmd_scheduler: TIMEOUT_CYCLES must be 2..8192 and CLOCK_FREQUENCY nonzero");
   end

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_LAUNCH    = 3'd1,
      ST_WAIT_DONE = 3'd2,
      ST_RELEASE   = 3'd3,
      ST_RESPOND   = 3'd4
   } state_t;

   state_t               state;
   logic [NUM_SUB-1:0]   sel_q;
   logic [TIMER_W-1:0]   timer;
   logic                 accept;
   logic                 complete_hit;

   // Handshake qualifier and completion flag of the owning sub-block only
   assign accept       = bus.cmd_valid & bus.cmd_ready;
   assign complete_hit = |(bus.complete_i & sel_q);

   // Command sequencing with all outputs registered
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state           <= ST_IDLE;
         sel_q           <= '0;
         timer           <= '0;
         bus.cmd_ready   <= 1'b1;
         bus.active_o    <= '0;
         bus.cmd_type_o  <= '0;
         bus.resp_valid  <= 1'b0;
         bus.resp_status <= STATUS_OK;
         bus.resp_count  <= '0;
         bus.busy        <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  bus.cmd_type_o <= bus.cmd_type;
                  bus.cmd_ready  <= 1'b0;
                  bus.busy       <= 1'b1;
                  if (bus.cmd_id <= ID_MAX) begin
                     sel_q <= NUM_SUB'(5'b00001 << bus.cmd_id);
                     state <= ST_LAUNCH;
                  end else begin
                     // Illegal id never owns the bus; answer straight away
                     sel_q           <= '0;
                     bus.resp_status <= STATUS_ILLEGAL;
                     bus.resp_count  <= '0;
                     bus.resp_valid  <= 1'b1;
                     state           <= ST_RESPOND;
                  end
               end
            end

            ST_LAUNCH: begin
               bus.active_o <= sel_q;
               timer        <= '0;
               state        <= ST_WAIT_DONE;
            end

            ST_WAIT_DONE: begin
               if (complete_hit) begin
                  bus.active_o    <= '0;
                  timer           <= '0;
                  bus.resp_status <= STATUS_OK;
                  bus.resp_count  <= bus.resp_count_i;
                  state           <= ST_RELEASE;
               end else if (timer == TIMER_LAST) begin
                  bus.active_o    <= '0;
                  timer           <= '0;
                  bus.resp_status <= STATUS_TIMEOUT;
                  bus.resp_count  <= '0;
                  state           <= ST_RELEASE;
               end else if (timer != TIMER_SAT) begin
                  timer <= timer + TIMER_W'(1);
               end
            end

            ST_RELEASE: begin
               if (!complete_hit) begin
                  timer          <= '0;
                  bus.resp_valid <= 1'b1;
                  state          <= ST_RESPOND;
               end else if (timer == TIMER_LAST) begin
                  // Sub-block never dropped its flag: report it, overriding OK
                  timer           <= '0;
                  bus.resp_status <= STATUS_STUCK;
                  bus.resp_count  <= '0;
                  bus.resp_valid  <= 1'b1;
                  state           <= ST_RESPOND;
               end else if (timer != TIMER_SAT) begin
                  timer <= timer + TIMER_W'(1);
               end
            end

            ST_RESPOND: begin
               if (bus.resp_ready) begin
                  bus.resp_valid  <= 1'b0;
                  bus.resp_status <= STATUS_OK;
                  bus.resp_count  <= '0;
                  bus.busy        <= 1'b0;
                  bus.cmd_ready   <= 1'b1;
                  state           <= ST_IDLE;
               end
            end

            default: begin
               bus.active_o   <= '0;
               bus.resp_valid <= 1'b0;
               bus.busy       <= 1'b0;
               bus.cmd_ready  <= 1'b1;
               state          <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_phase_bus_cmd_scheduler.sv
// Scoreboard bench for phase_bus_cmd_scheduler: directed commands push expected
// responses, a negedge monitor pops and compares them at each response handshake.
module tb_phase_bus_cmd_scheduler;

   localparam int unsigned TIMEOUT = 16;

   typedef struct packed {
      logic [1:0] status;
      logic [3:0] count;
   } resp_t;

   logic clock;
   logic reset;
   int   checks;
   int   failures;
   resp_t      exp_q[$];
   logic [4:0] exp_mask;

   phase_bus_cmd_scheduler_if bus ();

   phase_bus_cmd_scheduler #(
      .CLOCK_FREQUENCY (27000000),
      .TIMEOUT_CYCLES  (TIMEOUT)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   // 10-unit clock
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Runaway guard
   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got running required finished");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d required %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Response scoreboard and active-line ownership monitor
   always @(negedge clock) begin
      if (reset) begin
         if (bus.active_o != 5'b0)
            check("active_owner", 32'(bus.active_o & ~exp_mask), 32'd0);
         if (bus.resp_valid && bus.resp_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_resp", 32'(bus.resp_valid), 32'd0);
            end else begin
               resp_t e;
               e = exp_q.pop_front();
               check("resp_status", 32'(bus.resp_status), 32'(e.status));
               check("resp_count", 32'(bus.resp_count), 32'(e.count));
            end
         end
      end
   end

   task automatic send_cmd(input logic [2:0] id, input logic [1:0] typ);
      int w;
      bus.cmd_valid = 1'b1;
      bus.cmd_id    = id;
      bus.cmd_type  = typ;
      w = 0;
      while (!bus.cmd_ready && w < 50) begin
         tick();
         w++;
      end
      if (w >= 50) check("cmd_ready_wait", 32'(bus.cmd_ready), 32'd1);
      tick();
      bus.cmd_valid = 1'b0;
   endtask

   task automatic run_cmd(
      input logic [2:0] id, input logic [1:0] typ, input int done_after, input bit stuck,
      input logic [3:0] rc, input logic [4:0] stray, input int stray_at,
      input bit hold_next, input logic [2:0] nid, input logic [1:0] ntyp, input int stall,
      input logic [1:0] est, input logic [3:0] ecnt, input int eact, input int elat);
      logic [4:0] mask;
      logic [4:0] cmp;
      int cnt, lat;
      bit raised, stray_done;
      mask = (id <= 3'd4) ? 5'(5'b00001 << id) : 5'b00000;
      exp_q.push_back(resp_t'{est, ecnt});
      exp_mask = mask;
      bus.resp_count_i = rc;
      bus.complete_i   = stuck ? mask : 5'b0;
      send_cmd(id, typ);
      if (hold_next) begin
         bus.cmd_valid = 1'b1;
         bus.cmd_id    = nid;
         bus.cmd_type  = ntyp;
      end
      check("busy_after_accept", 32'(bus.busy), 32'd1);
      check("cmd_type_o", 32'(bus.cmd_type_o), 32'(typ));
      cnt = 0; lat = 0; raised = 1'b0; stray_done = 1'b0;
      while (!bus.resp_valid && lat < 200) begin
         if (mask != 5'b0 && bus.active_o == mask) cnt++;
         cmp = stuck ? mask : 5'b0;
         if (!raised && done_after > 0 && cnt == done_after) begin
            cmp = cmp | mask;
            raised = 1'b1;
         end
         if (stray != 5'b0 && !stray_done && cnt == stray_at) begin
            cmp = cmp | stray;
            stray_done = 1'b1;
         end
         bus.complete_i = cmp;
         tick();
         lat++;
      end
      if (lat >= 200) check("resp_valid_wait", 32'(bus.resp_valid), 32'd1);
      check("resp_latency", 32'(lat), 32'(elat));
      check("active_cycles", 32'(cnt), 32'(eact));
      check("cmd_type_hold", 32'(bus.cmd_type_o), 32'(typ));
      for (int i = 0; i < stall; i++) tick();
      check("resp_valid_stall", 32'(bus.resp_valid), 32'd1);
      check("cmd_ready_stall", 32'(bus.cmd_ready), 32'd0);
      bus.resp_ready = 1'b1;
      tick();
      bus.resp_ready = 1'b0;
      bus.complete_i = 5'b0;
      exp_mask = 5'b0;
      check("resp_valid_after", 32'(bus.resp_valid), 32'd0);
      check("busy_after", 32'(bus.busy), 32'd0);
      check("cmd_ready_after", 32'(bus.cmd_ready), 32'd1);
   endtask

   initial begin
      checks = 0;
      failures = 0;
      exp_mask = 5'b0;
      reset = 1'b0;
      bus.cmd_valid = 1'b0;
      bus.cmd_id = 3'd0;
      bus.cmd_type = 2'd0;
      bus.complete_i = 5'b0;
      bus.resp_count_i = 4'd0;
      bus.resp_ready = 1'b0;

      // Reset state
      #12;
      check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
      check("rst_active", 32'(bus.active_o), 32'd0);
      check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_status_count", 32'({bus.resp_status, bus.resp_count, bus.cmd_type_o}), 32'd0);
      tick();
      reset = 1'b1;
      tick();

      // T1 read4, completion after 10 active cycles
      run_cmd(3'd1, 2'd0, 10, 1'b0, 4'd4, 5'b0, 0, 1'b0, 3'd0, 2'd0, 2,
              2'd0, 4'd4, 10, 12);
      // write4 single-cycle completion, count > 4 passes through
      run_cmd(3'd0, 2'd3, 1, 1'b0, 4'd9, 5'b0, 0, 1'b0, 3'd0, 2'd0, 0,
              2'd0, 4'd9, 1, 3);
      // T2 illegal ids
      run_cmd(3'd6, 2'd1, 0, 1'b0, 4'd7, 5'b0, 0, 1'b0, 3'd0, 2'd0, 1,
              2'd1, 4'd0, 0, 0);
      run_cmd(3'd5, 2'd2, 0, 1'b0, 4'd3, 5'b0, 0, 1'b0, 3'd0, 2'd0, 0,
              2'd1, 4'd0, 0, 0);
      // T3 timeout on adc4
      run_cmd(3'd2, 2'd2, 0, 1'b0, 4'd5, 5'b0, 0, 1'b0, 3'd0, 2'd0, 0,
              2'd2, 4'd0, 16, 18);
      // T4 stuck complete on test
      run_cmd(3'd4, 2'd1, 0, 1'b1, 4'd3, 5'b0, 0, 1'b0, 3'd0, 2'd0, 0,
              2'd3, 4'd0, 1, 18);
      // T5 back-to-back with stalled response and stray completion
      run_cmd(3'd0, 2'd0, 4, 1'b0, 4'd2, 5'b00010, 2, 1'b1, 3'd3, 2'd2, 5,
              2'd0, 4'd2, 4, 6);
      run_cmd(3'd3, 2'd2, 1, 1'b0, 4'd1, 5'b0, 0, 1'b0, 3'd0, 2'd0, 0,
              2'd0, 4'd1, 1, 3);

      // T6 asynchronous reset while adc4 is in WAIT_DONE
      exp_mask = 5'b00100;
      send_cmd(3'd2, 2'd1);
      tick();
      tick();
      tick();
      check("t6_active_before", 32'(bus.active_o), 32'd4);
      #2;
      reset = 1'b0;
      #1;
      check("t6_active_async", 32'(bus.active_o), 32'd0);
      check("t6_resp_valid_async", 32'(bus.resp_valid), 32'd0);
      check("t6_busy_async", 32'(bus.busy), 32'd0);
      exp_mask = 5'b0;
      tick();
      tick();
      reset = 1'b1;
      tick();
      check("t6_cmd_ready", 32'(bus.cmd_ready), 32'd1);
      check("t6_busy", 32'(bus.busy), 32'd0);

      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
